// File: rtl/bp_stall_counter_reader_if.sv
// Snapshot stream from bp_stall_counter_reader: word, index, last flag, valid/ready.
interface bp_stall_counter_reader_if #(
  parameter int width_p  = 32,
  parameter int lg_els_p = 6
);
  logic [width_p-1:0]  data;
  logic                v;
  logic                ready;
  logic [lg_els_p-1:0] idx;
  logic                last;

  modport master (output data, output v, output idx, output last, input ready);
  modport slave  (input data, input v, input idx, input last, output ready);
endinterface

// File: rtl/bp_stall_counter_reader.sv
// Freezes all counters on request and streams the frozen copy one word per handshake.
// Define BP_STALL_READER_HEADER_EN to prefix each stream with a {16'hB5C0, seq} header word.
module bp_stall_counter_reader #(
  parameter int  width_p   = 32,
  parameter int  els_p     = 36,
  localparam int lg_els_lp = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [els_p*width_p-1:0] counters_i,
  input  logic                     snap_v_i,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     dropped_o,
  bp_stall_counter_reader_if.master strm_if
);

`ifdef BP_STALL_READER_HEADER_EN
  localparam int hdr_lp = 1;
`else
  localparam int hdr_lp = 0;
`endif

  localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1 + hdr_lp);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [lg_els_lp-1:0] idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 dropped_q, dropped_d;
  logic                 snap_en;
  logic [width_p-1:0]   snap_q [els_p];
  logic [width_p-1:0]   word;
  logic                 last;

`ifdef BP_STALL_READER_HEADER_EN
  logic [15:0]          seq_q, seq_d;
`endif

  // Snapshot storage is data only, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (snap_en) begin
      for (int k = 0; k < els_p; k++) begin
        snap_q[k] <= counters_i[k*width_p +: width_p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
`ifdef BP_STALL_READER_HEADER_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
`ifdef BP_STALL_READER_HEADER_EN
      seq_q     <= seq_d;
`endif
    end
  end

  assign last = (idx_q == last_idx_lp);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    dropped_d = dropped_q;
    snap_en   = 1'b0;
`ifdef BP_STALL_READER_HEADER_EN
    seq_d     = seq_q;
`endif
    if (clear_i) begin
      state_d   = IDLE;
      idx_d     = '0;
      dropped_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snap_v_i) begin
            snap_en = 1'b1;
            idx_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (snap_v_i) begin
            dropped_d = 1'b1;
          end
          if (strm_if.ready) begin
            if (last) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
`ifdef BP_STALL_READER_HEADER_EN
              seq_d   = seq_q + 16'd1;
`endif
            end else begin
              idx_d = idx_q + lg_els_lp'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter k sits at stream index k+hdr_lp; index 0 is the header when enabled.
  always_comb begin
    word = '0;
    for (int k = 0; k < els_p; k++) begin
      if (idx_q == lg_els_lp'(k + hdr_lp)) begin
        word = snap_q[k];
      end
    end
`ifdef BP_STALL_READER_HEADER_EN
    if (idx_q == '0) begin
      word = width_p'({16'hB5C0, seq_q});
    end
`endif
  end

  assign strm_if.v    = (state_q == SEND);
  assign strm_if.data = word;
  assign strm_if.idx  = idx_q;
  assign strm_if.last = (state_q == SEND) && last;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign dropped_o    = dropped_q;

endmodule

// File: doc/bp_stall_counter_reader.md
Name: bp_stall_counter_reader

Overview:
- Read-side companion to the stall/event counter bank.
- Atomically snapshots a flat vector of els_p free-running counters on request, then streams the snapshot word-by-word over a valid/ready interface toward the PS-facing host FIFO.
- Frozen snapshot gives the host a coherent sample while the counter bank keeps counting.

Parameters:
- width_p, 32, width of each counter and of the output word; must be >= 32.
- els_p, 36, number of counters in counters_i; must be >= 2.
- lg_els_lp, $clog2(els_p+1), localparam, width of idx_o.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- counters_i  in  els_p*width_p  live counter values; counter k at bits [k*width_p +: width_p].
- snap_v_i  in  1  snapshot request, one-cycle pulse or level.
- clear_i  in  1  synchronous abort; returns to IDLE.
- busy_o  out  1  high while not in IDLE.
- data_o  out  width_p  current stream word.
- v_o  out  1  stream valid.
- ready_i  in  1  stream ready from consumer.
- idx_o  out  lg_els_lp  index of the word on data_o.
- last_o  out  1  high with the final word of a snapshot.
- done_o  out  1  one-cycle pulse after the last word handshakes.
- dropped_o  out  1  sticky; a snap_v_i arrived while busy.

Behaviour:
- Reset (reset_n_i low, asynchronous): state=IDLE, idx=0, v_o=0, last_o=0, done_o=0, busy_o=0, dropped_o=0, sequence counter=0. Snapshot registers are not reset.
- States: IDLE, SEND.
- IDLE:
  - On snap_v_i & ~clear_i, latch all of counters_i into the snapshot array at that edge, idx=0, go to SEND.
  - v_o rises the next cycle, so first-word latency is 1 cycle.
- SEND:
  - v_o=1, data_o=snap[idx], idx_o=idx, last_o=(idx==els_p-1).
  - On v_o & ready_i: if not last, idx++; if last, go to IDLE, idx=0, assert done_o for the following cycle, and increment the sequence counter (16-bit, wraps 0xFFFF->0).
- Handshake: once v_o is high, data_o, idx_o and last_o stay stable until the handshake. v_o does not drop without a handshake except on clear_i or reset. v_o does not depend combinationally on ready_i.
- Back-to-back: with ready_i held high, one word per cycle; a full snapshot takes exactly els_p cycles in SEND.
- snap_v_i while busy (SEND, or the cycle done_o is high but state already IDLE counts as idle): in SEND the request is ignored and dropped_o sets. dropped_o clears only on reset or clear_i.
- A request in the same cycle the last word handshakes is dropped: state is still SEND.
- clear_i: highest priority. Next cycle state=IDLE, v_o=0, idx=0, dropped_o=0, no done_o. A snap_v_i in the same cycle is ignored. The sequence counter is unchanged.
- Reset mid-SEND: outputs return immediately to reset values. No partial-stream completion.
- Counter values are copied verbatim; no arithmetic on data. idx wraps only via return to IDLE and never reaches els_p.

Optional Feature:
- Macro: BP_STALL_READER_HEADER_EN.
- Defined:
  - Each snapshot is preceded by a header word: data_o = {zero-extend, 16'hB5C0, seq[15:0]}, where seq is the sequence counter value before increment.
  - idx_o=0 for the header; counter k appears with idx_o=k+1.
  - last_o is with idx_o=els_p.
  - A snapshot is els_p+1 words.
  - Counters are still latched at request time.
- Undefined: no header; behaviour exactly as above.

Test Plan:
- Reset then snap: els_p=4, counters={40,30,20,10} (k=0 is 10), ready_i=1, one-cycle snap_v_i -> v_o high 1 cycle later; data_o 10,20,30,40 on consecutive cycles with idx_o 0..3; last_o only on 40; done_o one cycle after; busy_o low thereafter.
- Snapshot coherency: counters increment every cycle; ready_i low for 5 cycles after v_o rises -> data_o stays at the value latched at the request edge for all 5 cycles, and every word matches the request-cycle values.
- Backpressure pattern: ready_i toggles 1,0,1,0 -> exactly one idx advance per ready cycle; total SEND duration 2*els_p-1 cycles; no word skipped or duplicated.
- Overrun: snap_v_i pulsed at idx_o=2 -> stream unaffected, dropped_o=1 and stays 1 after done_o; clear_i then gives dropped_o=0.
- Abort: clear_i at idx_o=1 -> v_o=0 next cycle, no done_o; a new snap then starts at idx_o=0 with fresh values. Async reset asserted mid-stream -> v_o=0 immediately, no clock required.
- With BP_STALL_READER_HEADER_EN: two snapshots -> headers 0xB5C00000 then 0xB5C00001; last_o at idx_o=els_p; each stream is els_p+1 words.
